// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | load_store_unit                                                    |
// | Memory-access stage: one req/ack data transaction at a time, with  |
// | store lane replication, load extension and misalignment faults.    |
// | Optional bus timeout: define LSU_TIMEOUT_EN.                       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_unsigned,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 2");
   end

   logic [1:0]  state;
   logic [1:0]  ld_size;
   logic        ld_unsigned;
   logic [1:0]  ld_off;
   logic        misaligned;
   logic [31:0] store_data;
   logic [3:0]  store_strb;
   logic [31:0] lane;
   logic [31:0] load_data;
   logic        timeout;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_comb begin
      misaligned = 1'b0;
      store_data = req_wdata;
      store_strb = 4'b1111;
      case (req_size)
         SZ_BYTE: begin
            store_data = {4{req_wdata[7:0]}};
            store_strb = 4'b0001 << req_addr[1:0];
         end
         SZ_HALF: begin
            misaligned = req_addr[0];
            store_data = {2{req_wdata[15:0]}};
            store_strb = 4'b0011 << req_addr[1:0];
         end
         SZ_WORD: misaligned = (req_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Accesses are naturally aligned, so shifting by the byte offset puts the lane at bit 0.
   assign lane = mem_rdata >> {ld_off, 3'b000};

   always_comb begin
      load_data = lane;
      case (ld_size)
         SZ_BYTE: load_data = ld_unsigned ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         SZ_HALF: load_data = ld_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_data = lane;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || state != S_ACCESS) begin
         wait_cnt <= '0;
      end else if (!mem_ack) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timeout = (state == S_ACCESS) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ld_size     <= 2'b00;
         ld_unsigned <= 1'b0;
         ld_off      <= 2'b00;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0;
         mem_wdata   <= 32'h0;
         mem_wstrb   <= 4'h0;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'h0;
         resp_fault  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  ld_size     <= req_size;
                  ld_unsigned <= req_unsigned;
                  ld_off      <= req_addr[1:0];
                  if (misaligned) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else begin
                     state     <= S_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= req_write;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= store_data;
                     mem_wstrb <= req_write ? store_strb : 4'h0;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack || timeout) begin
                  state      <= S_RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_wstrb  <= 4'h0;
                  resp_valid <= 1'b1;
                  resp_fault <= !mem_ack;
                  resp_rdata <= (mem_ack && !mem_we) ? load_data : 32'h0;
               end
            end
            S_RESP: begin
               state      <= S_IDLE;
               resp_valid <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
